// File: rtl/ps2_seq_pkg.sv
// Shared types and PS/2 response byte constants for the host command sequencer.
package ps2_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTx,
    StTxWait,
    StAckWait,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK         = 2'd0,
    STAT_DEV_ERR    = 2'd1,
    STAT_RESEND_EXH = 2'd2,
    STAT_TIMEOUT    = 2'd3
  } status_e;

  typedef enum logic {
    PhCmd,
    PhArg
  } phase_e;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERROR  = 8'hFC;

endpackage

// File: rtl/ps2_timeout_timer.sv
// Response timeout counter: synchronous clear and enable, terminal count at TIMEOUT_CYCLES-1.
module ps2_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TW             = 20
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: sends a command byte plus optional argument, handles
// ACK/RESEND/ERROR with bounded retries and a response timeout, forwards scan codes.
module ps2_cmd_sequencer
  import ps2_seq_pkg::*;
#(
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TW             = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] arg_byte,
  output logic       done,
  output logic [1:0] status,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_done,
  input  logic       tx_error,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] scan_data,
  output logic       scan_valid
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  status_e       status_q, status_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    cmd_q, cmd_d, arg_q, arg_d, scan_data_q, scan_data_d;
  logic          has_arg_q, has_arg_d, scan_valid_q, scan_valid_d;
  logic          timer_clr, timer_en, timer_tc, retry_req;

  ps2_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_timer (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .tc      (timer_tc)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    status_d     = status_q;
    retry_d      = retry_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    has_arg_d    = has_arg_q;
    scan_valid_d = 1'b0;
    scan_data_d  = scan_data_q;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;
    retry_req    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // In IDLE every received byte is a scan code, even ACK/RESEND/ERROR values.
        if (rx_valid) begin
          scan_valid_d = 1'b1;
          scan_data_d  = rx_data;
        end
        if (cmd_valid) begin
          cmd_d     = cmd_byte;
          arg_d     = arg_byte;
          has_arg_d = cmd_has_arg;
          phase_d   = PhCmd;
          retry_d   = '0;
          state_d   = StTx;
        end
      end
      StTx: state_d = StTxWait;
      StTxWait: begin
        if (tx_error) begin
          retry_req = 1'b1;
        end else if (tx_done) begin
          timer_clr = 1'b1;
          state_d   = StAckWait;
        end
      end
      StAckWait: begin
        timer_en = 1'b1;
        // A received byte takes priority over the timeout terminal count.
        if (rx_valid) begin
          case (rx_data)
            PS2_ACK: begin
              if (phase_q == PhCmd && has_arg_q) begin
                phase_d = PhArg;
                retry_d = '0;
                state_d = StTx;
              end else begin
                status_d = STAT_OK;
                state_d  = StDone;
              end
            end
            PS2_RESEND: retry_req = 1'b1;
            PS2_ERROR: begin
              status_d = STAT_DEV_ERR;
              state_d  = StDone;
            end
            default: begin
              scan_valid_d = 1'b1;
              scan_data_d  = rx_data;
            end
          endcase
        end else if (timer_tc) begin
          status_d = STAT_TIMEOUT;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (retry_req) begin
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d = retry_q + RW'(1);
        state_d = StTx;
      end else begin
        status_d = STAT_RESEND_EXH;
        state_d  = StDone;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= PhCmd;
      status_q     <= STAT_OK;
      retry_q      <= '0;
      cmd_q        <= 8'h00;
      arg_q        <= 8'h00;
      has_arg_q    <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      status_q     <= status_d;
      retry_q      <= retry_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      has_arg_q    <= has_arg_d;
      scan_valid_q <= scan_valid_d;
      scan_data_q  <= scan_data_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign tx_send    = (state_q == StTx);
  assign tx_data    = (phase_q == PhArg) ? arg_q : cmd_q;
  assign done       = (state_q == StDone);
  assign status     = status_q;
  assign scan_valid = scan_valid_q;
  assign scan_data  = scan_data_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer: table of command/response scenarios plus
// hand-written timeout, scan-forwarding and mid-operation reset sequences.
module tb_ps2_cmd_sequencer;

  localparam int unsigned TO = 100;
  localparam logic [8:0] ACK = 9'h0FA;
  localparam logic [8:0] RSD = 9'h0FE;
  localparam logic [8:0] ERR = 9'h0FC;
  localparam logic [8:0] TXE = 9'h100;  // bit 8: engine reports tx_error instead of tx_done

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_has_arg = 1'b0;
  logic [7:0] cmd_byte = 8'h00, arg_byte = 8'h00, rx_data = 8'h00;
  logic       tx_done = 1'b0, tx_error = 1'b0, rx_valid = 1'b0;
  logic       cmd_ready, done, tx_send, scan_valid;
  logic [1:0] status;
  logic [7:0] tx_data, scan_data;

  ps2_cmd_sequencer #(
    .MAX_RETRY     (3),
    .TIMEOUT_CYCLES(TO),
    .TW            (7)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_byte   (cmd_byte),
    .cmd_has_arg(cmd_has_arg),
    .arg_byte   (arg_byte),
    .done       (done),
    .status     (status),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .scan_data  (scan_data),
    .scan_valid (scan_valid)
  );

  always #10 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] cmd;
    logic       has_arg;
    logic [7:0] arg;
    logic [71:0] resp;  // up to 8 responses, entry 0 in the low 9 bits
    int         exp_sends;
    logic [1:0] exp_status;
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [7:0] cmd, input logic has_arg,
                              input logic [7:0] arg, input logic [71:0] resp, input int sends,
                              input logic [1:0] st);
    vec_t v;
    v.name = name; v.cmd = cmd; v.has_arg = has_arg; v.arg = arg;
    v.resp = resp; v.exp_sends = sends; v.exp_status = st;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    int nsent = 0, k = 0, idle = 0, cyc = 0;
    bit got_done = 0, ph_arg = 0;
    logic [8:0] r;
    logic [7:0] exp_b;
    check({v.name, " ready"}, 32'(cmd_ready), 32'd1);
    cmd_byte = v.cmd; arg_byte = v.arg; cmd_has_arg = v.has_arg; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; cmd_byte = 8'h00; arg_byte = 8'h00; cmd_has_arg = 1'b0;
    check({v.name, " first_send"}, 32'(tx_send), 32'd1);
    while (!got_done && cyc < 200) begin
      cyc++;
      if (done) begin
        got_done = 1;
      end else if (tx_send) begin
        exp_b = ph_arg ? v.arg : v.cmd;
        check({v.name, " tx_data"}, 32'(tx_data), 32'(exp_b));
        nsent++;
        r = ACK;
        if (k < 8) r = v.resp[k*9 +: 9];
        k++;
        step();
        if (r[8]) tx_error = 1'b1; else tx_done = 1'b1;
        step();
        tx_error = 1'b0; tx_done = 1'b0;
        if (!r[8]) begin
          rx_valid = 1'b1; rx_data = r[7:0];
          step();
          rx_valid = 1'b0;
          if (r == ACK && v.has_arg) ph_arg = 1;
        end
      end else begin
        idle++;
        step();
      end
    end
    check({v.name, " done_seen"}, 32'(got_done), 32'd1);
    check({v.name, " sends"}, 32'(nsent), 32'(v.exp_sends));
    check({v.name, " status"}, 32'(status), 32'(v.exp_status));
    check({v.name, " idle_cycles"}, 32'(idle), 32'd0);
    step();
    check({v.name, " done_one_cycle"}, 32'(done), 32'd0);
    check({v.name, " status_hold"}, 32'(status), 32'(v.exp_status));
    check({v.name, " ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_timeout(input bit ack_on_tc);
    int n = 0;
    bit early = 0;
    cmd_byte = 8'hF4; cmd_has_arg = 1'b0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("to tx_send", 32'(tx_send), 32'd1);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    // First ACK_WAIT cycle: timer at zero.
    if (ack_on_tc) begin
      repeat (TO - 1) begin
        if (done) early = 1;
        step();
      end
      rx_valid = 1'b1; rx_data = 8'hFA;
      step();
      rx_valid = 1'b0;
      check("tc_ack early_done", 32'(early), 32'd0);
      check("tc_ack done", 32'(done), 32'd1);
      check("tc_ack status", 32'(status), 32'd0);
    end else begin
      while (!done && n < 300) begin
        step();
        n++;
      end
      check("timeout cycles", 32'(n), 32'(TO));
      check("timeout status", 32'(status), 32'd3);
    end
    step();
  endtask

  initial begin
    vecs[0] = mk("led_set",   8'hED, 1'b1, 8'h07, {63'h0, ACK, ACK} >> 0, 2, 2'd0);
    vecs[1] = mk("resend_ok", 8'hF4, 1'b0, 8'h00, {45'h0, ACK, RSD, RSD}, 3, 2'd0);
    vecs[2] = mk("resend_ex", 8'hF4, 1'b0, 8'h00, {36'h0, RSD, RSD, RSD, RSD}, 4, 2'd2);
    vecs[3] = mk("txerr_ex",  8'hF4, 1'b0, 8'h00, {36'h0, TXE, TXE, TXE, TXE}, 4, 2'd2);
    vecs[4] = mk("dev_err",   8'hFF, 1'b0, 8'h00, {63'h0, ERR}, 1, 2'd1);
    vecs[5] = mk("retry_per_phase", 8'hF3, 1'b1, 8'h20,
                 {ACK, RSD, RSD, RSD, ACK, RSD, RSD, RSD}, 8, 2'd1 - 2'd1);
    vecs[6] = mk("arg_err",   8'hED, 1'b1, 8'h02, {54'h0, ERR, ACK}, 2, 2'd1);

    #2 reset = 1'b1;
    #3;
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst status", 32'(status), 32'd0);
    check("rst tx_send", 32'(tx_send), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst scan_valid", 32'(scan_valid), 32'd0);
    check("rst scan_data", 32'(scan_data), 32'd0);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

    run_timeout(1'b0);
    run_timeout(1'b1);

    // Scan forwarding in IDLE, including an ACK-valued byte.
    rx_valid = 1'b1; rx_data = 8'h1C;
    step();
    check("idle scan_valid", 32'(scan_valid), 32'd1);
    check("idle scan_data", 32'(scan_data), 32'h1C);
    rx_data = 8'hFA;
    step();
    rx_valid = 1'b0;
    check("idle scan_fa", 32'(scan_data), 32'hFA);
    step();
    check("idle scan_clear", 32'(scan_valid), 32'd0);

    // Scan code during ACK_WAIT; rx during TX_WAIT is ignored.
    cmd_byte = 8'hF4; cmd_has_arg = 1'b0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    rx_valid = 1'b1; rx_data = 8'h55;
    step();
    rx_valid = 1'b0;
    step();
    check("txwait rx_ignored", 32'(scan_valid), 32'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h32;
    step();
    rx_valid = 1'b0;
    check("ack_wait scan_valid", 32'(scan_valid), 32'd1);
    check("ack_wait scan_data", 32'(scan_data), 32'h32);
    check("ack_wait no_done", 32'(done), 32'd0);
    rx_valid = 1'b1; rx_data = 8'hFA;
    step();
    rx_valid = 1'b0;
    check("ack_wait done", 32'(done), 32'd1);
    check("ack_wait status", 32'(status), 32'd0);
    step();

    // Reset while in TX_WAIT.
    cmd_byte = 8'hED; cmd_has_arg = 1'b1; arg_byte = 8'h04; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst tx_send", 32'(tx_send), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("midrst no_done_after", 32'(done), 32'd0);
    apply_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
- Host-side command controller for the PS/2 keyboard link on the DE-series board.
- Sits between user logic (or the PS2_Comm front panel) and the PS/2 byte transmit/receive engine.
- Sends one command byte plus an optional argument byte, for example 0xED + LED mask or 0xF3 + typematic rate.
- Handles the device ACK/RESEND/ERROR responses, bounded retries and a response timeout. Any unsolicited received bytes (scan codes) are forwarded to the scan output.

Parameters:
- MAX_RETRY, 3: resend attempts per byte after the first try, before failing.
- TIMEOUT_CYCLES, 1000000: CLOCK_50 cycles to wait for a device response (20 ms).
- TW, 20: width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  request valid
- cmd_ready  output  1  sequencer idle and accepting a request
- cmd_byte  input  8  command byte
- cmd_has_arg  input  1  an argument byte follows the command
- arg_byte  input  8  argument byte
- done  output  1  one-cycle pulse when the request completes
- status  output  2  result, valid while done=1: 0 OK, 1 DEV_ERR, 2 RESEND_EXHAUSTED, 3 TIMEOUT
- tx_data  output  8  byte to the PS/2 transmit engine
- tx_send  output  1  one-cycle start pulse to the engine
- tx_done  input  1  engine finished the byte, device clocked it in
- tx_error  input  1  engine aborted the byte (no device clock or no line ACK)
- rx_data  input  8  byte from the PS/2 receive engine
- rx_valid  input  1  one-cycle strobe, rx_data is valid
- scan_data  output  8  forwarded unsolicited byte
- scan_valid  output  1  one-cycle strobe for scan_data

Behaviour:
- Reset values: cmd_ready=1, done=0, status=0, tx_send=0, tx_data=0, scan_valid=0, scan_data=0. State IDLE, retry count 0, timer 0.
- Reset mid-operation: immediate return to IDLE. No done pulse is issued and the partial request is dropped.
- States are IDLE, TX, TX_WAIT, ACK_WAIT, DONE. A phase bit selects CMD or ARG.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid=1, latch cmd_byte, arg_byte and cmd_has_arg; set phase=CMD and retry=0; go to TX.
  - cmd_ready=0 in every other state.
- TX:
  - tx_data = cmd_byte if phase=CMD, otherwise arg_byte.
  - tx_send=1 for exactly this one cycle; go to TX_WAIT.
- TX_WAIT:
  - tx_done: clear the timer, go to ACK_WAIT.
  - tx_error: treated as a resend (retry rule below).
  - If tx_done and tx_error are asserted together, tx_error wins.
  - No timeout applies in this state; the engine owns its own timeout.
- ACK_WAIT, timer increments every cycle:
  - rx_data=0xFA (ACK): if phase=CMD and has_arg, set phase=ARG and retry=0, go to TX. Otherwise go to DONE with status OK.
  - rx_data=0xFE (RESEND): apply the retry rule.
  - rx_data=0xFC (ERROR): go to DONE with status DEV_ERR.
  - Any other byte: forward to scan_data with scan_valid=1 (one cycle later), stay in ACK_WAIT, timer not cleared.
  - Timer reaches TIMEOUT_CYCLES-1 with no rx_valid: go to DONE with status TIMEOUT.
  - rx_valid in the same cycle as the timeout terminal count: the received byte wins.
- Retry rule:
  - If retry < MAX_RETRY: retry++, go to TX and resend the same byte of the current phase.
  - Otherwise go to DONE with status RESEND_EXHAUSTED.
  - retry resets to 0 at the start of each phase.
- DONE:
  - done=1 for one cycle, status is registered.
  - Go to IDLE; status holds its value until the next done.
- Outside ACK_WAIT:
  - In IDLE, every rx_valid byte is forwarded to scan, including 0xFA, 0xFE and 0xFC.
  - In TX, TX_WAIT and DONE, rx_valid is ignored.
- Latency: cmd_valid accepted to the first tx_send is 1 cycle. The final ACK to done is 1 cycle.

Decomposition:
- Package ps2_seq_pkg holds:
  - state enum;
  - status enum (STAT_OK, STAT_DEV_ERR, STAT_RESEND_EXH, STAT_TIMEOUT);
  - byte constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_ERROR=8'hFC.
- Sub-module ps2_timeout_timer:
  - TW-bit counter with synchronous clear and enable.
  - Terminal-count output at TIMEOUT_CYCLES-1.
  - Uses the same asynchronous active-high reset.

Test Plan:
- LED set: cmd 0xED, arg 0x07, has_arg=1; device ACKs both bytes -> two tx_send pulses (0xED, then 0x07), then done with status=0.
- Resend recovery: cmd 0xF4, no arg; device sends 0xFE twice, then 0xFA -> three tx_send pulses, all with tx_data 0xF4; done with status=0.
- Resend exhausted: MAX_RETRY=3, device always replies 0xFE -> four tx_send pulses, then done with status=2. Repeat with tx_error in place of 0xFE -> same result.
- Timeout: TIMEOUT_CYCLES=100, tx_done returned, no rx -> done with status=3 exactly 100 cycles after entering ACK_WAIT (+1 for DONE). Same run with rx_valid 0xFA on the terminal cycle -> status=0.
- Scan forwarding: in IDLE, rx 0x1C -> scan_valid with scan_data=0x1C. During ACK_WAIT, rx 0x32 then 0xFA -> 0x32 is forwarded and the command completes OK.
- Reset mid-op: assert reset while in TX_WAIT -> cmd_ready=1, tx_send=0, no done pulse. A new command after reset runs normally.
